// File: rtl/boxhead_pkg.sv
// ============================================================================
//  boxhead_pkg : shared screen geometry and blitter state encoding
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package boxhead_pkg;

  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CHECK = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } blit_state_t;

  // 11-bit sum so positions past the 10-bit screen range stay distinguishable
  function automatic logic [10:0] coord_sum(input logic [9:0] base, input logic [6:0] off);
    return {1'b0, base} + {4'b0000, off};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_blitter.sv
// ============================================================================
//  sprite_blitter : walks a sprite in ROM, drops keyed/off-screen pixels and
//  hands the rest one at a time to the SRAM controller program port.
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sprite_blitter
  import boxhead_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT,
  parameter int ROM_AW   = 16
) (
  input  logic              sram_clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x,
  input  logic [9:0]        cmd_y,
  input  logic [6:0]        cmd_w,
  input  logic [6:0]        cmd_h,
  input  logic [ROM_AW-1:0] cmd_base,
  input  logic [15:0]       cmd_key,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              pix_valid,
  input  logic              pix_accept,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  output logic [15:0]       pix_data,
  output logic              busy,
  output logic              done
);

  localparam logic [10:0]       c_SCREEN_W = 11'(SCREEN_W);
  localparam logic [10:0]       c_SCREEN_H = 11'(SCREEN_H);
  localparam logic [ROM_AW-1:0] c_ADDR_ONE = {{(ROM_AW-1){1'b0}}, 1'b1};

  blit_state_t       r_state;
  blit_state_t       w_next_state;

  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [6:0]        r_w;
  logic [6:0]        r_h;
  logic [15:0]       r_key;
  logic [ROM_AW-1:0] r_addr;
  logic [6:0]        r_col;
  logic [6:0]        r_row;
  logic [9:0]        r_pix_x;
  logic [9:0]        r_pix_y;
  logic [15:0]       r_pix_data;

  logic              w_accept;
  logic [10:0]       w_sx;
  logic [10:0]       w_sy;
  logic              w_skip;
  logic              w_col_end;
  logic              w_last;
  logic              w_advance;
  logic              w_draw;

  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign w_sx      = coord_sum(r_x, r_col);
  assign w_sy      = coord_sum(r_y, r_row);
  assign w_skip    = (rom_data == r_key) || (w_sx >= c_SCREEN_W) || (w_sy >= c_SCREEN_H);
  assign w_col_end = (r_col == (r_w - 7'd1));
  assign w_last    = w_col_end && (r_row == (r_h - 7'd1));
  assign w_draw    = (r_state == ST_CHECK) && !w_skip;
  // pix_accept only counts while a pixel is actually being offered
  assign w_advance = ((r_state == ST_CHECK) && w_skip) ||
                     ((r_state == ST_EMIT) && pix_accept);

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    pix_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if ((cmd_w == 7'd0) || (cmd_h == 7'd0)) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (!w_skip) begin
          w_next_state = ST_EMIT;
        end else if (w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_EMIT: begin
        pix_valid = 1'b1;
        if (pix_accept) begin
          w_next_state = w_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_key      <= '0;
      r_addr     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_pix_x    <= '0;
      r_pix_y    <= '0;
      r_pix_data <= '0;
    end else begin
      if (w_accept) begin
        r_x    <= cmd_x;
        r_y    <= cmd_y;
        r_w    <= cmd_w;
        r_h    <= cmd_h;
        r_key  <= cmd_key;
        r_addr <= cmd_base;
        r_col  <= '0;
        r_row  <= '0;
      end else if (w_advance) begin
        // Row-major walk: the address simply increments, so no stride multiply
        r_addr <= r_addr + c_ADDR_ONE;
        if (w_col_end) begin
          r_col <= '0;
          r_row <= r_row + 7'd1;
        end else begin
          r_col <= r_col + 7'd1;
        end
      end
      if (w_draw) begin
        r_pix_x    <= w_sx[9:0];
        r_pix_y    <= w_sy[9:0];
        r_pix_data <= rom_data;
      end
    end
  end

  assign rom_addr = r_addr;
  assign pix_x    = r_pix_x;
  assign pix_y    = r_pix_y;
  assign pix_data = r_pix_data;

endmodule

`default_nettype wire

// File: tb/tb_sprite_blitter.sv
// ============================================================================
//  tb_sprite_blitter : directed stimulus with a pixel/done scoreboard
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_blitter;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [9:0]  cmd_y;
  logic [6:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [15:0] cmd_base;
  logic [15:0] cmd_key;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        pix_valid;
  logic        pix_accept;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic        busy;
  logic        done;

  logic        acc_en;
  logic        acc_gen;
  logic        acc_manual;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] d;
    logic [15:0] a;
  } pix_t;

  pix_t exp_q[$];
  int   exp_done_q[$];
  int   checks;
  int   errors;
  int   done_total;
  int   since_done;
  logic prev_done;

  logic [15:0] rom [0:65535];

  sprite_blitter #(
    .SCREEN_W(640),
    .SCREEN_H(480),
    .ROM_AW  (16)
  ) dut (
    .sram_clk  (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_base  (cmd_base),
    .cmd_key   (cmd_key),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_valid (pix_valid),
    .pix_accept(pix_accept),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_data  (pix_data),
    .busy      (busy),
    .done      (done)
  );

  assign pix_accept = acc_gen | acc_manual;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous sprite ROM: data for the address presented is valid next cycle
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pix(input logic [9:0] x, input logic [9:0] y,
                          input logic [15:0] d, input logic [15:0] a);
    pix_t p;
    p.x = x; p.y = y; p.d = d; p.a = a;
    exp_q.push_back(p);
  endtask

  // Returns after the handshake edge; waited = negedges seen before cmd_ready
  task automatic issue(input logic [9:0] x, input logic [9:0] y, input logic [6:0] w,
                       input logic [6:0] h, input logic [15:0] base, input logic [15:0] key,
                       output int waited);
    @(posedge clk); #1;
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_base = base; cmd_key = key;
    cmd_valid = 1'b1;
    waited = 0;
    while (waited < 200) begin
      @(negedge clk);
      waited++;
      if (cmd_ready) break;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_handshake: got cmd_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int target;
    int n;
    target = done_total + 1;
    n = 0;
    while ((done_total < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (done_total < target) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
    chk("pixels_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (pix_valid) break;
    end
    if (!pix_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout: got pix_valid 0 expected 1 within %0d cycles", budget);
    end
  endtask

  // Pulses pix_accept on every second cycle whenever enabled
  initial begin
    int cnt;
    cnt = 0;
    acc_gen = 1'b0;
    forever begin
      @(posedge clk); #1;
      cnt++;
      acc_gen = acc_en & cnt[0];
    end
  end

  // Scoreboard monitor
  initial begin
    pix_t e;
    since_done = 0;
    prev_done  = 1'b0;
    done_total = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        since_done = 0;
        prev_done  = 1'b0;
      end else begin
        if (pix_valid && pix_accept) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pixel: got (%0d,%0d) data 0x%0h expected none",
                     pix_x, pix_y, pix_data);
          end else begin
            e = exp_q.pop_front();
            chk("pix_x", 64'(pix_x), 64'(e.x));
            chk("pix_y", 64'(pix_y), 64'(e.y));
            chk("pix_data", 64'(pix_data), 64'(e.d));
            chk("rom_addr_of_pixel", 64'(rom_addr), 64'(e.a));
          end
          since_done++;
        end
        if (done) begin
          done_total++;
          if (prev_done) begin
            checks++; errors++;
            $display("FAIL done_width: got done high 2 cycles expected 1");
          end
          if (exp_done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done expected none");
          end else begin
            chk("pixels_per_cmd", 64'(since_done), 64'(exp_done_q.pop_front()));
          end
          since_done = 0;
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [15:0] cd;

    checks = 0; errors = 0;
    for (int i = 0; i < 65536; i++) rom[i] = 16'h1234;
    rom_data = 16'h0;
    reset_n = 1'b0; cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_base = '0; cmd_key = '0;
    acc_en = 1'b0; acc_manual = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_pix_regs", 64'({pix_x, pix_y, pix_data}), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic 2x2 sprite, accept every second cycle
    acc_en = 1'b1;
    push_pix(10'd10, 10'd20, 16'h1234, 16'h0100);
    push_pix(10'd11, 10'd20, 16'h1234, 16'h0101);
    push_pix(10'd10, 10'd21, 16'h1234, 16'h0102);
    push_pix(10'd11, 10'd21, 16'h1234, 16'h0103);
    exp_done_q.push_back(4);
    issue(10'd10, 10'd20, 7'd2, 7'd2, 16'h0100, 16'hF81F, w);
    wait_done(200);

    // Transparent pixel at (11,20)
    rom[16'h0101] = 16'hF81F;
    push_pix(10'd10, 10'd20, 16'h1234, 16'h0100);
    push_pix(10'd10, 10'd21, 16'h1234, 16'h0102);
    push_pix(10'd11, 10'd21, 16'h1234, 16'h0103);
    exp_done_q.push_back(3);
    issue(10'd10, 10'd20, 7'd2, 7'd2, 16'h0100, 16'hF81F, w);
    wait_done(200);
    rom[16'h0101] = 16'h1234;

    // Clipping at the bottom-right corner
    push_pix(10'd638, 10'd479, 16'h1234, 16'h0200);
    push_pix(10'd639, 10'd479, 16'h1234, 16'h0201);
    exp_done_q.push_back(2);
    issue(10'd638, 10'd479, 7'd4, 7'd2, 16'h0200, 16'hF81F, w);
    wait_done(200);

    // Zero-width command goes straight to DONE
    exp_done_q.push_back(0);
    issue(10'd1, 10'd1, 7'd0, 7'd5, 16'h0300, 16'hF81F, w);
    @(negedge clk);
    chk("zero_w_done_ready", 64'({done, cmd_ready}), 64'b10);
    @(negedge clk);
    chk("zero_w_back_idle", 64'({done, cmd_ready}), 64'b01);

    // Back-pressure: accept held low, latency, stability, busy command ignored
    acc_en = 1'b0;
    rom[16'h0300] = 16'h5A5A;
    push_pix(10'd100, 10'd50, 16'h5A5A, 16'h0300);
    push_pix(10'd101, 10'd50, 16'h1234, 16'h0301);
    exp_done_q.push_back(2);
    issue(10'd100, 10'd50, 7'd2, 7'd1, 16'h0300, 16'hF81F, w);
    wait_valid(10, n);
    chk("first_pixel_latency", 64'(n), 64'd3);
    cx = pix_x; cy = pix_y; cd = pix_data;
    chk("first_pixel_value", 64'({cx, cy, cd}), 64'({10'd100, 10'd50, 16'h5A5A}));
    @(posedge clk); #1;
    cmd_x = 10'd0; cmd_y = 10'd0; cmd_w = 7'd1; cmd_h = 7'd1; cmd_base = 16'h0000;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_stable", 64'({pix_valid, cmd_ready, busy, pix_x, pix_y, pix_data}),
          64'({1'b1, 1'b0, 1'b1, cx, cy, cd}));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_en = 1'b1;
    wait_done(200);
    rom[16'h0300] = 16'h1234;
    repeat (4) @(negedge clk);

    // Reset while pixel 2 of 4 is on offer
    acc_en = 1'b0;
    push_pix(10'd30, 10'd40, 16'h1234, 16'h0400);
    issue(10'd30, 10'd40, 7'd4, 7'd1, 16'h0400, 16'hF81F, w);
    wait_valid(10, n);
    @(posedge clk); #1;
    acc_manual = 1'b1;
    @(posedge clk); #1;
    acc_manual = 1'b0;
    wait_valid(10, n);
    chk("second_pixel_x", 64'(pix_x), 64'd31);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("reset_kills_pixel", 64'({pix_valid, busy, done, cmd_ready}), 64'b0001);
    acc_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_done_on_reset", 64'(done_total), 64'd5);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rom[16'h0500] = 16'hABCD;
    push_pix(10'd5, 10'd6, 16'hABCD, 16'h0500);
    exp_done_q.push_back(1);
    issue(10'd5, 10'd6, 7'd1, 7'd1, 16'h0500, 16'hF81F, w);
    chk("accept_first_cycle", 64'(w), 64'd1);
    wait_done(200);
    repeat (4) @(negedge clk);

    chk("done_total", 64'(done_total), 64'd6);
    chk("done_outstanding", 64'(exp_done_q.size()), 64'd0);
    chk("final_idle", 64'({busy, cmd_ready, pix_valid}), 64'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter SCREEN_W, default 640, frame width in pixels for clipping.
REQ-002 Parameter SCREEN_H, default 480, frame height in pixels for clipping.
REQ-003 Parameter ROM_AW, default 16, sprite ROM address width.
REQ-004 sram_clk  in  1  single clock, 100 MHz domain shared with the SRAM controller.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  draw command offered.
REQ-007 cmd_ready  out  1  blitter accepts a command this cycle.
REQ-008 cmd_x, cmd_y  in  10 each  sprite top-left screen position, unsigned.
REQ-009 cmd_w, cmd_h  in  7 each  sprite width/height, 0..64 legal.
REQ-010 cmd_base  in  ROM_AW  ROM address of sprite pixel (0,0), row-major, stride cmd_w.
REQ-011 cmd_key  in  16  transparent colour key.
REQ-012 rom_addr  out  ROM_AW  synchronous sprite ROM address; rom_data valid exactly 1 cycle later.
REQ-013 rom_data  in  16  sprite ROM read data.
REQ-014 pix_valid  out  1  pixel write request to SRAM controller program port.
REQ-015 pix_accept  in  1  controller consumed the pixel (one pulse per program write slot).
REQ-016 pix_x, pix_y  out  10 each  screen coordinate of pixel; pix_data  out  16  colour.
REQ-017 busy  out  1  command in progress; done  out  1  one-cycle completion pulse.

Function
REQ-018 States IDLE, FETCH, CHECK, EMIT, DONE; only IDLE asserts cmd_ready.
REQ-019 Handshake cmd_valid&&cmd_ready latches all cmd_* fields; IDLE->FETCH, or IDLE->DONE if cmd_w==0 or cmd_h==0.
REQ-020 FETCH drives rom_addr from a running address counter (start cmd_base, +1 per pixel, mod 2^ROM_AW, no multiplier); FETCH->CHECK.
REQ-021 CHECK evaluates rom_data with 11-bit sums sx=cmd_x+col, sy=cmd_y+row; pixel skipped if rom_data==cmd_key, sx>=SCREEN_W or sy>=SCREEN_H.
REQ-022 Skipped pixel: advance counters, CHECK->FETCH (or DONE if last), no pix_valid.
REQ-023 Drawn pixel: register pix_x=sx[9:0], pix_y=sy[9:0], pix_data=rom_data; CHECK->EMIT.
REQ-024 EMIT holds pix_valid=1 and pix_x/pix_y/pix_data stable until pix_accept=1; on accept advance counters, ->FETCH or ->DONE if last.
REQ-025 pix_accept while pix_valid=0 SHALL be ignored.
REQ-026 Counter order: col 0..cmd_w-1 within row, then row+1, col=0; last pixel = (cmd_w-1, cmd_h-1).
REQ-027 DONE asserts done for exactly one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-028 cmd_valid while busy SHALL be ignored and not queued.
REQ-029 Latency: cmd accept to first pix_valid = 3 cycles (FETCH, CHECK, EMIT) when pixel 0 is drawn.

Reset
REQ-030 reset_n low SHALL immediately force IDLE; cmd_ready=1, pix_valid=0, busy=0, done=0, rom_addr=0, pix_x=pix_y=0, pix_data=0.
REQ-031 Reset mid-command SHALL abandon the command with no done pulse; no pixel emitted after reset asserts.
REQ-032 After reset_n rises, a new command is accepted on the first cycle cmd_valid=1.

Structure
REQ-033 SCREEN_W/SCREEN_H defaults and state enum SHALL live in shared package boxhead_pkg.
REQ-034 Single module, no sub-module; sprite ROM instantiated outside the block.

Verification
REQ-035 Cmd x=10,y=20,w=2,h=2,base=0x100,key=0xF81F, ROM all 0x1234, pix_accept every 2nd cycle -> 4 pixels (10,20),(11,20),(10,21),(11,21) data 0x1234, rom_addr 0x100..0x103, one done.
REQ-036 Same cmd, ROM[0x101]=0xF81F -> 3 pixels, (11,20) absent, done after 3rd accept.
REQ-037 Cmd x=638,y=479,w=4,h=2 -> only (638,479),(639,479) emitted; 6 pixels skipped; done asserted.
REQ-038 Cmd w=0,h=5 -> no pix_valid, done one cycle after accept, cmd_ready back next cycle.
REQ-039 pix_accept held low 20 cycles in EMIT -> pix_valid and pix_x/pix_y/pix_data stable throughout; second cmd_valid during busy ignored.
REQ-040 reset_n low during EMIT of pixel 2 of 4 -> pix_valid=0 same cycle, no done, next cmd drawn from pixel 0.
